mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port (the AXI read/write bridge interface) between the instruction-fetch requester and the memory-stage requester of the CPU pipeline. Fixed priority: memory stage over fetch. The memory stage is the older instruction. A granted transaction's command is latched and held on the downstream port until completion. A fetch killed by a pipeline flush is drained and its response discarded.

## Interface
Parameters:
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `if_valid`  in  1  fetch request pending
- `if_addr`  in  ADDR_W  fetch address
- `if_size`  in  2  fetch size (`SIZE_B/H/W/D`)
- `if_kill`  in  1  pipeline flush; discard any fetch in flight
- `if_ready`  out  1  fetch completion pulse
- `if_rdata`  out  DATA_W  fetch read data, valid with `if_ready`
- `if_resp`  out  2  fetch response code, valid with `if_ready`
- `me_valid`  in  1  memory-stage request pending
- `me_req`  in  1  `REQ_READ` (0) / `REQ_WRITE` (1)
- `me_addr`  in  ADDR_W  data address
- `me_size`  in  2  data size
- `me_wdata`  in  DATA_W  store data
- `me_ready`  out  1  data completion pulse
- `me_rdata`  out  DATA_W  load data, valid with `me_ready`
- `me_resp`  out  2  data response code, valid with `me_ready`
- `rw_valid`  out  1  downstream request valid
- `rw_req`  out  1  downstream read/write
- `rw_addr`  out  ADDR_W  downstream address
- `rw_size`  out  2  downstream size
- `rw_w_data`  out  DATA_W  downstream write data
- `rw_ready`  in  1  downstream completion pulse, one cycle
- `rw_r_data`  in  DATA_W  downstream read data
- `rw_resp`  in  2  downstream response

## Operation
- FSM states: IDLE, IF_GNT, ME_GNT, IF_DROP.
- IDLE:
  - `me_valid` → latch `me_req/addr/size/wdata`, go to ME_GNT.
  - Else `if_valid & ~if_kill` → latch `if_addr/size` with `rw_req`=`REQ_READ` and `rw_w_data`=0, go to IF_GNT.
  - Else stay.
- IF_GNT:
  - `rw_ready & ~if_kill` → `if_ready`=1, go to IDLE.
  - `rw_ready & if_kill` → `if_ready`=0, response dropped, go to IDLE.
  - `~rw_ready & if_kill` → go to IF_DROP.
- IF_DROP: `rw_ready` → go to IDLE. `if_ready` is never asserted in this state.
- ME_GNT: `rw_ready` → `me_ready`=1, go to IDLE. `if_kill` has no effect on this state.
- `rw_valid` = 1 in IF_GNT, ME_GNT and IF_DROP. `rw_req/addr/size/w_data` come from the latched registers.
- Downstream transactions are never aborted. A transaction in flight always runs to `rw_ready`.
- Completion outputs are combinational:
  - `if_ready` = (state==IF_GNT) & `rw_ready` & ~`if_kill`.
  - `me_ready` = (state==ME_GNT) & `rw_ready`.
  - `if_rdata`/`me_rdata` = `rw_r_data`; `if_resp`/`me_resp` = `rw_resp`. Both pass through unconditionally and are meaningful only with their ready.
- Requesters hold valid and fields until their ready. The arbiter ignores field changes after the latch.
- `rw_ready` observed in IDLE is ignored.

## Timing
- Reset, synchronous: state=IDLE; all latched command registers=0. Hence `rw_valid`=0, `rw_req`=0, `rw_addr`=0, `rw_size`=0, `rw_w_data`=0, `if_ready`=0, `me_ready`=0.
- Reset mid-transaction returns to IDLE immediately. Completing the downstream side is the responsibility of the bridge reset.
- Request latency: valid sampled in IDLE at cycle N → `rw_valid`=1 from cycle N+1.
- Completion: `rw_ready` at cycle M → owner ready in cycle M (same cycle). State is IDLE at M+1, so the next grant is at M+1 and `rw_valid` is re-asserted at M+2.
- Minimum spacing between back-to-back transactions: `rw_valid` deasserted for exactly one cycle.
- Simultaneous `if_valid` and `me_valid` in IDLE → ME granted. IF waits and is granted at the next IDLE if it is still valid and not killed.

## Test plan
- Single fetch:
  - Stimulus: `if_valid`=1, `if_addr`=0x8000_0000, `if_size`=`SIZE_D`; `rw_ready` pulsed 3 cycles after `rw_valid` with `rw_r_data`=0x0000_0013_0000_0013.
  - Response: `rw_valid` rises at N+1 with `rw_req`=0; `if_ready`=1 with matching `if_rdata` in the `rw_ready` cycle; `rw_valid`=0 the next cycle.
- Priority:
  - Stimulus: `if_valid` and `me_valid` rise in the same cycle; `me_req`=1, `me_addr`=0x8000_1000, `me_wdata`=0xDEAD_BEEF.
  - Response: the write is issued first with `rw_w_data`=0xDEAD_BEEF. After `me_ready`, one idle cycle, then the fetch with `rw_addr`=`if_addr`.
- Kill mid-flight: `if_kill` pulsed 1 cycle into IF_GNT → `rw_valid` held until `rw_ready`; `if_ready` stays 0 throughout; back to IDLE afterwards.
- Kill coincident with completion: `if_kill`=1 and `rw_ready`=1 in the same IF_GNT cycle → `if_ready`=0; state IDLE next cycle.
- Field stability:
  - Stimulus: change `me_addr` and `me_size` while in ME_GNT.
  - Response: `rw_addr`/`rw_size` keep the originally latched values.
- Reset mid-transaction: `reset` asserted in ME_GNT → next cycle `rw_valid`=0, all `rw_*` outputs 0, state IDLE; a later `rw_ready` is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory-stage requesters, the arbiter and the
// downstream read/write bridge port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  // Instruction-fetch requester
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [1:0]        if_size;
  logic              if_kill;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic [1:0]        if_resp;

  // Memory-stage requester
  logic              me_valid;
  logic              me_req;
  logic [ADDR_W-1:0] me_addr;
  logic [1:0]        me_size;
  logic [DATA_W-1:0] me_wdata;
  logic              me_ready;
  logic [DATA_W-1:0] me_rdata;
  logic [1:0]        me_resp;

  // Downstream bridge port
  logic              rw_valid;
  logic              rw_req;
  logic [ADDR_W-1:0] rw_addr;
  logic [1:0]        rw_size;
  logic [DATA_W-1:0] rw_w_data;
  logic              rw_ready;
  logic [DATA_W-1:0] rw_r_data;
  logic [1:0]        rw_resp;

  // Arbiter view
  modport slave (
    input  if_valid, if_addr, if_size, if_kill,
    output if_ready, if_rdata, if_resp,
    input  me_valid, me_req, me_addr, me_size, me_wdata,
    output me_ready, me_rdata, me_resp,
    output rw_valid, rw_req, rw_addr, rw_size, rw_w_data,
    input  rw_ready, rw_r_data, rw_resp
  );

  // Environment view (requesters plus bridge)
  modport master (
    output if_valid, if_addr, if_size, if_kill,
    input  if_ready, if_rdata, if_resp,
    output me_valid, me_req, me_addr, me_size, me_wdata,
    input  me_ready, me_rdata, me_resp,
    input  rw_valid, rw_req, rw_addr, rw_size, rw_w_data,
    output rw_ready, rw_r_data, rw_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between the memory stage
// (high priority) and instruction fetch; killed fetches are drained silently.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SIZE_W   = 2;
  localparam logic        REQ_READ = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_GNT  = 2'd1,
    S_ME_GNT  = 2'd2,
    S_IF_DROP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                req_q,   req_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [SIZE_W-1:0]   size_q,  size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  // State and latched command registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  // Grant selection and transaction tracking; command only latched in IDLE
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.me_valid) begin
          state_d = S_ME_GNT;
          req_d   = bus.me_req;
          addr_d  = ADDR_W'(bus.me_addr);
          size_d  = SIZE_W'(bus.me_size);
          wdata_d = DATA_W'(bus.me_wdata);
        end else if (bus.if_valid && !bus.if_kill) begin
          state_d = S_IF_GNT;
          req_d   = REQ_READ;
          addr_d  = ADDR_W'(bus.if_addr);
          size_d  = SIZE_W'(bus.if_size);
          wdata_d = '0;
        end
      end
      S_IF_GNT: begin
        if (bus.rw_ready) begin
          state_d = S_IDLE;
        end else if (bus.if_kill) begin
          state_d = S_IF_DROP;
        end
      end
      S_IF_DROP: begin
        if (bus.rw_ready) state_d = S_IDLE;
      end
      S_ME_GNT: begin
        if (bus.rw_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Downstream command comes straight from the latched registers
  assign bus.rw_valid  = (state_q != S_IDLE);
  assign bus.rw_req    = req_q;
  assign bus.rw_addr   = addr_q;
  assign bus.rw_size   = size_q;
  assign bus.rw_w_data = wdata_q;

  // Same-cycle completion; a kill in the completing cycle swallows the response
  assign bus.if_ready  = (state_q == S_IF_GNT) && bus.rw_ready && !bus.if_kill;
  assign bus.me_ready  = (state_q == S_ME_GNT) && bus.rw_ready;
  assign bus.if_rdata  = bus.rw_r_data;
  assign bus.if_resp   = bus.rw_resp;
  assign bus.me_rdata  = bus.rw_r_data;
  assign bus.me_resp   = bus.rw_resp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs are then driven there
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid  = 1'b0;
    bus.if_addr   = '0;
    bus.if_size   = 2'd0;
    bus.if_kill   = 1'b0;
    bus.me_valid  = 1'b0;
    bus.me_req    = 1'b0;
    bus.me_addr   = '0;
    bus.me_size   = 2'd0;
    bus.me_wdata  = '0;
    bus.rw_ready  = 1'b0;
    bus.rw_r_data = '0;
    bus.rw_resp   = 2'd0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_rw_valid", 64'(bus.rw_valid), 64'd0);
    chk("rst_rw_req",   64'(bus.rw_req),   64'd0);
    chk("rst_rw_addr",  64'(bus.rw_addr),  64'd0);
    chk("rst_rw_size",  64'(bus.rw_size),  64'd0);
    chk("rst_rw_wdata", 64'(bus.rw_w_data), 64'd0);
    chk("rst_if_ready", 64'(bus.if_ready), 64'd0);
    chk("rst_me_ready", 64'(bus.me_ready), 64'd0);

    // Single fetch
    step();
    bus.if_valid = 1'b1;
    bus.if_addr  = 64'h0000_0000_8000_0000;
    bus.if_size  = 2'd3;
    #1;
    chk("f1_idle_rw_valid", 64'(bus.rw_valid), 64'd0);
    step();
    #1;
    chk("f1_rw_valid", 64'(bus.rw_valid), 64'd1);
    chk("f1_rw_req",   64'(bus.rw_req),   64'd0);
    chk("f1_rw_addr",  64'(bus.rw_addr),  64'h0000_0000_8000_0000);
    chk("f1_rw_size",  64'(bus.rw_size),  64'd3);
    chk("f1_rw_wdata", 64'(bus.rw_w_data), 64'd0);
    chk("f1_wait_if_ready", 64'(bus.if_ready), 64'd0);
    step();
    step();
    step();
    bus.rw_ready  = 1'b1;
    bus.rw_r_data = 64'h0000_0013_0000_0013;
    #1;
    chk("f1_if_ready", 64'(bus.if_ready), 64'd1);
    chk("f1_if_rdata", 64'(bus.if_rdata), 64'h0000_0013_0000_0013);
    chk("f1_me_ready", 64'(bus.me_ready), 64'd0);
    step();
    idle_inputs();
    #1;
    chk("f1_after_rw_valid", 64'(bus.rw_valid), 64'd0);

    // Priority: write wins, then fetch after one idle cycle
    step();
    bus.if_valid = 1'b1;
    bus.if_addr  = 64'h0000_0000_8000_2000;
    bus.if_size  = 2'd2;
    bus.me_valid = 1'b1;
    bus.me_req   = 1'b1;
    bus.me_addr  = 64'h0000_0000_8000_1000;
    bus.me_size  = 2'd3;
    bus.me_wdata = 64'h0000_0000_DEAD_BEEF;
    step();
    #1;
    chk("pr_me_rw_valid", 64'(bus.rw_valid), 64'd1);
    chk("pr_me_rw_req",   64'(bus.rw_req),   64'd1);
    chk("pr_me_rw_addr",  64'(bus.rw_addr),  64'h0000_0000_8000_1000);
    chk("pr_me_rw_wdata", 64'(bus.rw_w_data), 64'h0000_0000_DEAD_BEEF);
    step();
    bus.rw_ready = 1'b1;
    bus.rw_resp  = 2'd1;
    #1;
    chk("pr_me_ready",    64'(bus.me_ready), 64'd1);
    chk("pr_me_resp",     64'(bus.me_resp),  64'd1);
    chk("pr_if_ready_lo", 64'(bus.if_ready), 64'd0);
    step();
    bus.rw_ready = 1'b0;
    bus.rw_resp  = 2'd0;
    bus.me_valid = 1'b0;
    #1;
    chk("pr_gap_rw_valid", 64'(bus.rw_valid), 64'd0);
    step();
    #1;
    chk("pr_if_rw_valid", 64'(bus.rw_valid), 64'd1);
    chk("pr_if_rw_req",   64'(bus.rw_req),   64'd0);
    chk("pr_if_rw_addr",  64'(bus.rw_addr),  64'h0000_0000_8000_2000);
    chk("pr_if_rw_size",  64'(bus.rw_size),  64'd2);
    chk("pr_if_rw_wdata", 64'(bus.rw_w_data), 64'd0);
    step();
    bus.rw_ready = 1'b1;
    #1;
    chk("pr_if_ready", 64'(bus.if_ready), 64'd1);
    step();
    idle_inputs();

    // Kill mid-flight: transaction drains, no fetch completion
    step();
    bus.if_valid = 1'b1;
    bus.if_addr  = 64'h0000_0000_8000_3000;
    step();
    #1;
    chk("km_rw_valid", 64'(bus.rw_valid), 64'd1);
    step();
    bus.if_kill = 1'b1;
    #1;
    chk("km_kill_if_ready", 64'(bus.if_ready), 64'd0);
    step();
    bus.if_kill  = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    chk("km_drop_rw_valid", 64'(bus.rw_valid), 64'd1);
    step();
    bus.rw_ready = 1'b1;
    #1;
    chk("km_drop_if_ready", 64'(bus.if_ready), 64'd0);
    chk("km_drop_valid",    64'(bus.rw_valid), 64'd1);
    step();
    bus.rw_ready = 1'b0;
    #1;
    chk("km_after_rw_valid", 64'(bus.rw_valid), 64'd0);

    // Kill coincident with completion
    step();
    bus.if_valid = 1'b1;
    bus.if_addr  = 64'h0000_0000_8000_4000;
    step();
    bus.if_kill  = 1'b1;
    bus.rw_ready = 1'b1;
    #1;
    chk("kc_if_ready", 64'(bus.if_ready), 64'd0);
    step();
    idle_inputs();
    #1;
    chk("kc_after_rw_valid", 64'(bus.rw_valid), 64'd0);

    // Fetch with kill already asserted in IDLE is never granted
    step();
    bus.if_valid = 1'b1;
    bus.if_kill  = 1'b1;
    step();
    #1;
    chk("ki_rw_valid", 64'(bus.rw_valid), 64'd0);
    idle_inputs();

    // Field stability while in ME_GNT
    step();
    bus.me_valid = 1'b1;
    bus.me_req   = 1'b0;
    bus.me_addr  = 64'h0000_0000_0000_1000;
    bus.me_size  = 2'd1;
    step();
    bus.me_addr  = 64'h0000_0000_0000_FFF8;
    bus.me_size  = 2'd3;
    step();
    #1;
    chk("fs_rw_addr", 64'(bus.rw_addr), 64'h0000_0000_0000_1000);
    chk("fs_rw_size", 64'(bus.rw_size), 64'd1);
    chk("fs_rw_req",  64'(bus.rw_req),  64'd0);
    bus.rw_ready  = 1'b1;
    bus.rw_r_data = 64'h0123_4567_89AB_CDEF;
    bus.rw_resp   = 2'd2;
    bus.if_kill   = 1'b1;
    #1;
    chk("fs_me_ready", 64'(bus.me_ready), 64'd1);
    chk("fs_me_rdata", 64'(bus.me_rdata), 64'h0123_4567_89AB_CDEF);
    chk("fs_me_resp",  64'(bus.me_resp),  64'd2);
    step();
    idle_inputs();

    // Reset mid-transaction
    step();
    bus.me_valid = 1'b1;
    bus.me_req   = 1'b1;
    bus.me_addr  = 64'h0000_0000_0000_2000;
    bus.me_size  = 2'd2;
    bus.me_wdata = 64'h0000_0000_0000_0055;
    step();
    #1;
    chk("rm_rw_valid", 64'(bus.rw_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.me_valid = 1'b0;
    #1;
    chk("rm_rw_valid_lo", 64'(bus.rw_valid), 64'd0);
    chk("rm_rw_req",      64'(bus.rw_req),   64'd0);
    chk("rm_rw_addr",     64'(bus.rw_addr),  64'd0);
    chk("rm_rw_size",     64'(bus.rw_size),  64'd0);
    chk("rm_rw_wdata",    64'(bus.rw_w_data), 64'd0);
    step();
    bus.rw_ready = 1'b1;
    #1;
    chk("rm_me_ready", 64'(bus.me_ready), 64'd0);
    chk("rm_if_ready", 64'(bus.if_ready), 64'd0);
    step();
    bus.rw_ready = 1'b0;
    #1;
    chk("rm_idle_rw_valid", 64'(bus.rw_valid), 64'd0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
